load_store_unit: RTL

LOAD_STORE_UNIT -- requirements
Module: load_store_unit

---
 rtl/load_store_unit.sv | 246 ++++++++++++++++++++++++
 1 files changed

// File: rtl/load_store_unit.sv
// Load/store unit: a three-state FSM that issues one data-memory access at a time and
// formats load data. The optional misalignment trap is enabled by defining LSU_MISALIGN_TRAP_EN.
module load_store_unit #(
  parameter int XLEN         = 32,
  parameter int MSB_REG_FILE = 5
) (
  input  logic                    clk,
  input  logic                    rstn,
  // execute side
  input  logic [XLEN-1:0]         alu_out,
  input  logic [XLEN-1:0]         rs2_data,
  input  logic [MSB_REG_FILE-1:0] rd_addr,
  input  logic                    ctrl_reg_wr,
  input  logic [XLEN-1:0]         pc_pls4,
  input  logic                    ctrl_dmem_req,
  input  logic                    ctrl_dmem_write,
  input  logic                    ctrl_dmem_l_unsigned,
  input  logic [1:0]              ctrl_dmem_n_bytes,
  // memory side
  output logic                    dmem_req,
  output logic                    dmem_we,
  output logic [XLEN-1:0]         dmem_addr,
  output logic [3:0]              dmem_be,
  output logic [XLEN-1:0]         dmem_wdata,
  input  logic                    dmem_gnt,
  input  logic                    dmem_rvalid,
  input  logic [XLEN-1:0]         dmem_rdata,
  // writeback side
  output logic [XLEN-1:0]         wb_data,
  output logic [XLEN-1:0]         pc_pls4_out,
  output logic [MSB_REG_FILE-1:0] rd_out,
  output logic                    reg_wr_out,
  output logic                    stall,
  output logic                    misalign,
  output logic [XLEN-1:0]         misalign_addr
);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    REQ       = 2'd1,
    WAIT_RESP = 2'd2
  } state_t;

  state_t                  state_q, state_d;
  logic [XLEN-1:0]         addr_q, addr_d;
  logic [XLEN-1:0]         data_q, data_d;
  logic [XLEN-1:0]         pc_q, pc_d;
  logic [1:0]              size_q, size_d;
  logic                    uns_q, uns_d;
  logic                    write_q, write_d;
  logic                    reg_wr_q, reg_wr_d;
  logic [MSB_REG_FILE-1:0] rd_q, rd_d;

  logic [XLEN-1:0]         wb_data_q, wb_data_d;
  logic [XLEN-1:0]         pc_out_q, pc_out_d;
  logic [MSB_REG_FILE-1:0] rd_out_q, rd_out_d;
  logic                    reg_wr_out_q, reg_wr_out_d;

  // Incoming request decode; an untrapped misaligned address is forced to natural alignment.
  logic            in_half, in_word;
  logic [XLEN-1:0] aligned_addr;

  assign in_half = (ctrl_dmem_n_bytes == 2'b01);
  assign in_word = ctrl_dmem_n_bytes[1];

  always_comb begin
    aligned_addr = alu_out;
    if (in_word) begin
      aligned_addr[1:0] = 2'b00;
    end else if (in_half) begin
      aligned_addr[0] = 1'b0;
    end
  end

`ifdef LSU_MISALIGN_TRAP_EN
  logic            mis_in;
  logic            misalign_q, misalign_d;
  logic [XLEN-1:0] misalign_addr_q, misalign_addr_d;

  assign mis_in        = (in_half && alu_out[0]) || (in_word && (alu_out[1:0] != 2'b00));
  assign misalign      = misalign_q;
  assign misalign_addr = misalign_addr_q;
`else
  assign misalign      = 1'b0;
  assign misalign_addr = '0;
`endif

  // Store lanes and load formatting, all driven from the holding registers.
  logic            hold_byte, hold_half;
  logic [XLEN-1:0] wdata_byte, wdata_half, store_wdata;
  logic [3:0]      store_be;
  logic [7:0]      ld_byte;
  logic [15:0]     ld_half;
  logic [XLEN-1:0] load_data;

  assign hold_byte = (size_q == 2'b00);
  assign hold_half = (size_q == 2'b01);

  genvar gi;
  generate
    for (gi = 0; gi < XLEN / 8; gi++) begin : g_byte_lane
      assign wdata_byte[gi*8 +: 8] = data_q[7:0];
    end
    for (gi = 0; gi < XLEN / 16; gi++) begin : g_half_lane
      assign wdata_half[gi*16 +: 16] = data_q[15:0];
    end
  endgenerate

  assign store_wdata = hold_byte ? wdata_byte : (hold_half ? wdata_half : data_q);
  assign ld_byte     = dmem_rdata[{addr_q[1:0], 3'b000} +: 8];
  assign ld_half     = dmem_rdata[{addr_q[1], 4'b0000} +: 16];

  always_comb begin
    store_be  = 4'b1111;
    load_data = dmem_rdata;
    if (hold_byte) begin
      store_be  = 4'b0001 << addr_q[1:0];
      load_data = {{(XLEN-8){~uns_q & ld_byte[7]}}, ld_byte};
    end else if (hold_half) begin
      store_be  = 4'b0011 << addr_q[1:0];
      load_data = {{(XLEN-16){~uns_q & ld_half[15]}}, ld_half};
    end
  end

  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    data_d       = data_q;
    pc_d         = pc_q;
    size_d       = size_q;
    uns_d        = uns_q;
    write_d      = write_q;
    reg_wr_d     = reg_wr_q;
    rd_d         = rd_q;
    wb_data_d    = wb_data_q;
    pc_out_d     = pc_out_q;
    rd_out_d     = rd_out_q;
    reg_wr_out_d = 1'b0;
    stall        = 1'b0;
    dmem_req     = 1'b0;
    dmem_we      = 1'b0;
    dmem_addr    = '0;
    dmem_be      = 4'b0000;
    dmem_wdata   = '0;
`ifdef LSU_MISALIGN_TRAP_EN
    misalign_d      = 1'b0;
    misalign_addr_d = misalign_addr_q;
`endif
    case (state_q)
      IDLE: begin
        if (!ctrl_dmem_req) begin
          wb_data_d    = alu_out;
          rd_out_d     = rd_addr;
          reg_wr_out_d = ctrl_reg_wr;
          pc_out_d     = pc_pls4;
`ifdef LSU_MISALIGN_TRAP_EN
        end else if (mis_in) begin
          misalign_d      = 1'b1;
          misalign_addr_d = alu_out;
`endif
        end else begin
          addr_d   = aligned_addr;
          data_d   = rs2_data;
          size_d   = ctrl_dmem_n_bytes;
          uns_d    = ctrl_dmem_l_unsigned;
          write_d  = ctrl_dmem_write;
          rd_d     = rd_addr;
          reg_wr_d = ctrl_reg_wr;
          pc_d     = pc_pls4;
          state_d  = REQ;
          stall    = 1'b1;
        end
      end
      REQ: begin
        dmem_req   = 1'b1;
        dmem_we    = write_q;
        dmem_addr  = {addr_q[XLEN-1:2], 2'b00};
        dmem_be    = store_be;
        dmem_wdata = store_wdata;
        if (dmem_gnt) begin
          state_d = write_q ? IDLE : WAIT_RESP;
        end else begin
          stall = 1'b1;
        end
      end
      WAIT_RESP: begin
        if (dmem_rvalid) begin
          state_d      = IDLE;
          wb_data_d    = load_data;
          rd_out_d     = rd_q;
          reg_wr_out_d = reg_wr_q;
          pc_out_d     = pc_q;
        end else begin
          stall = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q      <= IDLE;
      addr_q       <= '0;
      data_q       <= '0;
      pc_q         <= '0;
      size_q       <= 2'b00;
      uns_q        <= 1'b0;
      write_q      <= 1'b0;
      reg_wr_q     <= 1'b0;
      rd_q         <= '0;
      wb_data_q    <= '0;
      pc_out_q     <= '0;
      rd_out_q     <= '0;
      reg_wr_out_q <= 1'b0;
`ifdef LSU_MISALIGN_TRAP_EN
      misalign_q      <= 1'b0;
      misalign_addr_q <= '0;
`endif
    end else begin
      state_q      <= state_d;
      addr_q       <= addr_d;
      data_q       <= data_d;
      pc_q         <= pc_d;
      size_q       <= size_d;
      uns_q        <= uns_d;
      write_q      <= write_d;
      reg_wr_q     <= reg_wr_d;
      rd_q         <= rd_d;
      wb_data_q    <= wb_data_d;
      pc_out_q     <= pc_out_d;
      rd_out_q     <= rd_out_d;
      reg_wr_out_q <= reg_wr_out_d;
`ifdef LSU_MISALIGN_TRAP_EN
      misalign_q      <= misalign_d;
      misalign_addr_q <= misalign_addr_d;
`endif
    end
  end

  assign wb_data     = wb_data_q;
  assign pc_pls4_out = pc_out_q;
  assign rd_out      = rd_out_q;
  assign reg_wr_out  = reg_wr_out_q;

endmodule
